// File: rtl/ctr_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package ctr_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        JR       = 4'd11,
        COP0     = 4'd12,
        HALT     = 4'd13
    } state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_JR, CLS_SYSCALL, CLS_LW, CLS_SW, CLS_IMM,
        CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_COP0, CLS_ILLEGAL
    } cls_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_COP0  = 6'b010000;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_LUI   = 4'd4;
    localparam logic [3:0] ALU_FUNCT = 4'd5;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int WCNT_W          = 16;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       bneorbeq;
        logic       jump;
        logic       isjal;
        logic       isjr;
        logic       iscop0;
        logic       halt;
        logic [3:0] aluop;
    } ctl_t;

endpackage

// File: rtl/ctr_decode.sv
// Combinational opcode/funct classifier and ALU-operation lookup.
module ctr_decode
    import ctr_mc_pkg::*;
#(
    parameter int HAS_COP0 = 1
) (
    input  logic [5:0] op,
    input  logic [5:0] func,
    output cls_e       cls,
    output logic [3:0] aluop
);

    always_comb begin
        cls   = CLS_ILLEGAL;
        aluop = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                if (func == FN_JR) begin
                    cls = CLS_JR;
                end else if (func == FN_SYSCALL) begin
                    cls = CLS_SYSCALL;
                end else begin
                    cls   = CLS_R;
                    aluop = ALU_FUNCT;
                end
            end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_ADDI: cls = CLS_IMM;
            OP_ANDI: begin cls = CLS_IMM; aluop = ALU_AND; end
            OP_ORI:  begin cls = CLS_IMM; aluop = ALU_OR;  end
            OP_LUI:  begin cls = CLS_IMM; aluop = ALU_LUI; end
            OP_BEQ:  begin cls = CLS_BEQ; aluop = ALU_SUB; end
            OP_BNE:  begin cls = CLS_BNE; aluop = ALU_SUB; end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            OP_COP0: if (HAS_COP0 != 0) cls = CLS_COP0;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctr_unit_mc.sv
// Multicycle MIPS control FSM with bounded memory waits and sticky halt.
module ctr_unit_mc
    import ctr_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int HAS_COP0    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrc,
    output logic       branch,
    output logic       bneorbeq,
    output logic       jump,
    output logic       isjal,
    output logic       isjr,
    output logic       iscop0,
    output logic [3:0] aluop,
    output logic       halt,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam logic [WCNT_W-1:0] TO_LIMIT = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               mem_to_q, mem_to_d;
    cls_e               cls;
    logic [3:0]         dec_aluop;
    logic               wait_st;
    logic               timeout;
    ctl_t               ctl, ctl_g;

    ctr_decode #(.HAS_COP0(HAS_COP0)) u_decode (
        .op    (op),
        .func  (func),
        .cls   (cls),
        .aluop (dec_aluop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            wcnt_q   <= '0;
            mem_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            mem_to_q <= mem_to_d;
        end
    end

    // A completing access always beats the limit: timeout only fires on a not-ready cycle.
    always_comb begin
        wait_st  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
        timeout  = wait_st && !mem_ready && (MEM_TIMEOUT != 0) && ((wcnt_q + WCNT_ONE) == TO_LIMIT);
        wcnt_d   = '0;
        if (wait_st && !mem_ready && !timeout && (wcnt_q != '1)) begin
            wcnt_d = wcnt_q + WCNT_ONE;
        end
        mem_to_d = mem_to_q | timeout;
    end

    always_comb begin
        state_d   = state_q;
        ctl       = '0;
        ctl.aluop = ALU_ADD;
        case (state_q)
            FETCH: begin
                ctl.memread = 1'b1;
                if (timeout) begin
                    state_d = HALT;
                end else if (mem_ready) begin
                    ctl.irwrite = 1'b1;
                    ctl.pcwrite = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                case (cls)
                    CLS_R:            state_d = EXEC_R;
                    CLS_JR:           state_d = JR;
                    CLS_LW, CLS_SW:   state_d = MEM_ADDR;
                    CLS_IMM:          state_d = EXEC_I;
                    CLS_BEQ, CLS_BNE: state_d = BRANCH;
                    CLS_J, CLS_JAL:   state_d = JUMP;
                    CLS_COP0:         state_d = COP0;
                    default:          state_d = HALT;
                endcase
            end
            EXEC_R: begin
                ctl.aluop = dec_aluop;
                state_d   = WB_ALU;
            end
            EXEC_I: begin
                ctl.alusrc = 1'b1;
                ctl.aluop  = dec_aluop;
                state_d    = WB_ALU;
            end
            WB_ALU: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = (cls == CLS_R);
                state_d      = FETCH;
            end
            MEM_ADDR: begin
                ctl.alusrc = 1'b1;
                state_d    = (cls == CLS_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctl.memread = 1'b1;
                ctl.iord    = 1'b1;
                if (timeout)        state_d = HALT;
                else if (mem_ready) state_d = WB_MEM;
            end
            WB_MEM: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 1'b1;
                state_d      = FETCH;
            end
            MEM_WR: begin
                ctl.memwrite = 1'b1;
                ctl.iord     = 1'b1;
                if (timeout)        state_d = HALT;
                else if (mem_ready) state_d = FETCH;
            end
            BRANCH: begin
                ctl.branch   = 1'b1;
                ctl.bneorbeq = (cls == CLS_BNE);
                ctl.aluop    = ALU_SUB;
                state_d      = FETCH;
            end
            JUMP: begin
                ctl.jump     = 1'b1;
                ctl.isjal    = (cls == CLS_JAL);
                ctl.regwrite = (cls == CLS_JAL);
                state_d      = FETCH;
            end
            JR: begin
                ctl.isjr    = 1'b1;
                ctl.pcwrite = 1'b1;
                state_d     = FETCH;
            end
            COP0: begin
                ctl.iscop0   = 1'b1;
                ctl.regwrite = 1'b1;
                state_d      = FETCH;
            end
            HALT: begin
                ctl.halt = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset blanks every output combinationally, not just from the next edge.
    assign ctl_g       = rst ? '0 : ctl;
    assign state       = rst ? 4'd0 : state_q;
    assign mem_timeout = ~rst & mem_to_q;
    assign pcwrite     = ctl_g.pcwrite;
    assign irwrite     = ctl_g.irwrite;
    assign iord        = ctl_g.iord;
    assign memread     = ctl_g.memread;
    assign memwrite    = ctl_g.memwrite;
    assign regwrite    = ctl_g.regwrite;
    assign regdst      = ctl_g.regdst;
    assign memtoreg    = ctl_g.memtoreg;
    assign alusrc      = ctl_g.alusrc;
    assign branch      = ctl_g.branch;
    assign bneorbeq    = ctl_g.bneorbeq;
    assign jump        = ctl_g.jump;
    assign isjal       = ctl_g.isjal;
    assign isjr        = ctl_g.isjr;
    assign iscop0      = ctl_g.iscop0;
    assign aluop       = ctl_g.aluop;
    assign halt        = ctl_g.halt;

endmodule

// File: tb/tb_ctr_unit_mc.sv
// Bench for ctr_unit_mc: directed scenarios plus randomized instruction stream vs. a cost model.
module tb_ctr_unit_mc;
    import ctr_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;

    logic a_pcwrite, a_irwrite, a_iord, a_memread, a_memwrite, a_regwrite, a_regdst;
    logic a_memtoreg, a_alusrc, a_branch, a_bneorbeq, a_jump, a_isjal, a_isjr, a_iscop0;
    logic a_halt, a_mem_timeout;
    logic [3:0] a_aluop, a_state;
    logic b_pcwrite, b_irwrite, b_iord, b_memread, b_memwrite, b_regwrite, b_regdst;
    logic b_memtoreg, b_alusrc, b_branch, b_bneorbeq, b_jump, b_isjal, b_isjr, b_iscop0;
    logic b_halt, b_mem_timeout;
    logic [3:0] b_aluop, b_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctr_unit_mc #(.MEM_TIMEOUT(4), .HAS_COP0(1)) dut_a (
        .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
        .pcwrite(a_pcwrite), .irwrite(a_irwrite), .iord(a_iord), .memread(a_memread),
        .memwrite(a_memwrite), .regwrite(a_regwrite), .regdst(a_regdst), .memtoreg(a_memtoreg),
        .alusrc(a_alusrc), .branch(a_branch), .bneorbeq(a_bneorbeq), .jump(a_jump),
        .isjal(a_isjal), .isjr(a_isjr), .iscop0(a_iscop0), .aluop(a_aluop), .halt(a_halt),
        .mem_timeout(a_mem_timeout), .state(a_state)
    );

    ctr_unit_mc #(.MEM_TIMEOUT(0), .HAS_COP0(0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
        .pcwrite(b_pcwrite), .irwrite(b_irwrite), .iord(b_iord), .memread(b_memread),
        .memwrite(b_memwrite), .regwrite(b_regwrite), .regdst(b_regdst), .memtoreg(b_memtoreg),
        .alusrc(b_alusrc), .branch(b_branch), .bneorbeq(b_bneorbeq), .jump(b_jump),
        .isjal(b_isjal), .isjr(b_isjr), .iscop0(b_iscop0), .aluop(b_aluop), .halt(b_halt),
        .mem_timeout(b_mem_timeout), .state(b_state)
    );

    logic [24:0] a_outs;
    assign a_outs = {a_pcwrite, a_irwrite, a_iord, a_memread, a_memwrite, a_regwrite, a_regdst,
                     a_memtoreg, a_alusrc, a_branch, a_bneorbeq, a_jump, a_isjal, a_isjr,
                     a_iscop0, a_halt, a_mem_timeout, a_aluop, a_state};

    // Drive one cycle's inputs on the falling edge and let outputs settle.
    task automatic tick(input logic r, input logic rdy);
        @(negedge clk);
        rst       = r;
        mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        op = OP_RTYPE; func = 6'b100000;
        do_reset();
        checks++;
        if (a_outs !== '0) begin
            errors++; $display("FAIL reset_outs got=%h exp=0", a_outs);
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if (a_outs !== '0) begin
            errors++; $display("FAIL reset_mid_outs got=%h exp=0", a_outs);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (a_state !== 4'd0 || a_memread !== 1'b1 || a_halt !== 1'b0) begin
            errors++; $display("FAIL reset_release state=%0d memread=%b halt=%b exp 0/1/0", a_state, a_memread, a_halt);
        end
    endtask

    task automatic test_add();
        state_e es[5] = '{FETCH, DECODE, EXEC_R, WB_ALU, FETCH};
        logic   er[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        op = OP_RTYPE; func = 6'b100000;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, c == 0);
            checks++;
            if (a_state !== es[c] || a_regwrite !== er[c] || a_regdst !== er[c]) begin
                errors++;
                $display("FAIL add cyc%0d state=%0d rw=%b rd=%b exp state=%0d rw=%b rd=%b",
                         c, a_state, a_regwrite, a_regdst, es[c], er[c], er[c]);
            end
            if (c == 0) begin
                checks++;
                if (a_irwrite !== 1'b1 || a_pcwrite !== 1'b1 || a_aluop !== ALU_ADD) begin
                    errors++; $display("FAIL add_fetch ir=%b pc=%b alu=%0d exp 1/1/0", a_irwrite, a_pcwrite, a_aluop);
                end
            end
            if (c == 2) begin
                checks++;
                if (a_aluop !== ALU_FUNCT) begin
                    errors++; $display("FAIL add_aluop got=%0d exp=%0d", a_aluop, ALU_FUNCT);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        state_e     es[9]  = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_RD, WB_MEM, FETCH};
        logic       rd[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] ef[9]  = '{4'b1000, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0011, 4'b1000};
        do_reset();
        op = OP_LW; func = 6'($urandom);
        for (int c = 0; c < 9; c++) begin
            tick(1'b0, rd[c]);
            checks++;
            if (a_state !== es[c] || {a_memread, a_iord, a_regwrite, a_memtoreg} !== ef[c]) begin
                errors++;
                $display("FAIL lw cyc%0d state=%0d flags=%b exp state=%0d flags=%b",
                         c, a_state, {a_memread, a_iord, a_regwrite, a_memtoreg}, es[c], ef[c]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        op = OP_RTYPE; func = 6'b100000;
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        checks++;
        if (a_state !== DECODE || a_halt !== 1'b0) begin
            errors++; $display("FAIL timeout_edge_ready state=%0d halt=%b exp %0d/0", a_state, a_halt, DECODE);
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (a_state !== FETCH || a_halt !== 1'b0) begin
                errors++; $display("FAIL timeout_wait cyc%0d state=%0d halt=%b exp 0/0", c, a_state, a_halt);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (a_state !== HALT || a_halt !== 1'b1 || a_mem_timeout !== 1'b1 || a_memread !== 1'b0) begin
                errors++;
                $display("FAIL timeout_halt cyc%0d state=%0d halt=%b mto=%b mr=%b exp %0d/1/1/0",
                         c, a_state, a_halt, a_mem_timeout, a_memread, HALT);
            end
        end
        tick(1'b1, 1'b0);
        checks++;
        if (a_outs !== '0) begin
            errors++; $display("FAIL timeout_rst_outs got=%h exp=0", a_outs);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (a_state !== FETCH || a_halt !== 1'b0 || a_mem_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_clear state=%0d halt=%b mto=%b exp 0/0/0", a_state, a_halt, a_mem_timeout);
        end
        do_reset();
        for (int c = 0; c < 20; c++) tick(1'b0, 1'b0);
        checks++;
        if (b_state !== FETCH || b_halt !== 1'b0 || b_mem_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_disabled state=%0d halt=%b mto=%b exp 0/0/0", b_state, b_halt, b_mem_timeout);
        end
    endtask

    task automatic test_halt_ops();
        logic [5:0] ops[3]   = '{OP_RTYPE, OP_COP0, 6'b111111};
        logic [5:0] funcs[3] = '{FN_SYSCALL, 6'b000000, 6'b000000};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            op = ops[i]; func = funcs[i];
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b1);
            if (i != 1) begin
                checks++;
                if (a_state !== HALT || a_halt !== 1'b1 || a_mem_timeout !== 1'b0 || a_memread !== 1'b0 || a_regwrite !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_op%0d state=%0d halt=%b mto=%b mr=%b rw=%b exp %0d/1/0/0/0",
                             i, a_state, a_halt, a_mem_timeout, a_memread, a_regwrite, HALT);
                end
            end else begin
                checks++;
                if (a_state !== COP0 || a_iscop0 !== 1'b1 || a_regwrite !== 1'b1) begin
                    errors++; $display("FAIL cop0_on state=%0d iscop0=%b rw=%b exp %0d/1/1", a_state, a_iscop0, a_regwrite, COP0);
                end
                checks++;
                if (b_state !== HALT || b_halt !== 1'b1 || b_mem_timeout !== 1'b0 || b_iscop0 !== 1'b0) begin
                    errors++; $display("FAIL cop0_off state=%0d halt=%b mto=%b iscop0=%b exp %0d/1/0/0", b_state, b_halt, b_mem_timeout, b_iscop0, HALT);
                end
                tick(1'b0, 1'b0);
                checks++;
                if (a_state !== FETCH) begin
                    errors++; $display("FAIL cop0_return state=%0d exp 0", a_state);
                end
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops[5]   = '{OP_BNE, OP_BEQ, OP_JAL, OP_J, OP_RTYPE};
        state_e     es[5]    = '{BRANCH, BRANCH, JUMP, JUMP, JR};
        // {branch, bneorbeq, jump, isjal, isjr, pcwrite, regwrite}
        logic [6:0] ef[5]    = '{7'b1100000, 7'b1000000, 7'b0011001, 7'b0010000, 7'b0000110};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            op = ops[i]; func = FN_JR;
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            checks++;
            if (a_state !== es[i] || {a_branch, a_bneorbeq, a_jump, a_isjal, a_isjr, a_pcwrite, a_regwrite} !== ef[i]
                || (es[i] == BRANCH && a_aluop !== ALU_SUB)) begin
                errors++;
                $display("FAIL pcsrc op%0d state=%0d flags=%b alu=%0d exp state=%0d flags=%b",
                         i, a_state, {a_branch, a_bneorbeq, a_jump, a_isjal, a_isjr, a_pcwrite, a_regwrite},
                         a_aluop, es[i], ef[i]);
            end
            tick(1'b0, 1'b0);
            checks++;
            if (a_state !== FETCH) begin
                errors++; $display("FAIL pcsrc_return op%0d state=%0d exp 0", i, a_state);
            end
        end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        op = OP_SW; func = '0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (a_state !== MEM_WR || a_memwrite !== 1'b1 || a_iord !== 1'b1) begin
            errors++; $display("FAIL sw_wait state=%0d mw=%b iord=%b exp %0d/1/1", a_state, a_memwrite, a_iord, MEM_WR);
        end
        tick(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (a_state !== FETCH || a_memwrite !== 1'b0 || a_halt !== 1'b0) begin
                errors++; $display("FAIL midwait_rst cyc%0d state=%0d mw=%b halt=%b exp 0/0/0", c, a_state, a_memwrite, a_halt);
            end
        end
        tick(1'b0, 1'b0);
        checks++;
        if (a_state !== HALT || a_mem_timeout !== 1'b1) begin
            errors++; $display("FAIL midwait_cnt state=%0d mto=%b exp %0d/1", a_state, a_mem_timeout, HALT);
        end
    endtask

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_COP0} kind_e;

    task automatic test_random();
        logic [5:0] iops[4]  = '{OP_ADDI, OP_ANDI, OP_ORI, OP_LUI};
        logic [3:0] ialus[4] = '{ALU_ADD, ALU_AND, ALU_OR, ALU_LUI};
        do_reset();
        for (int n = 0; n < 60; n++) begin
            state_e     q[$];
            logic       rq[$];
            kind_e      k   = kind_e'($urandom_range(0, 9));
            int         fw  = $urandom_range(0, 3);
            int         mw  = $urandom_range(0, 3);
            int         sel = $urandom_range(0, 3);
            logic [3:0] exp_alu = ALU_ADD;
            int         nrw = 0, nmr = 0, nmw = 0;
            int         exp_rw, exp_mr, exp_mw;
            func = 6'($urandom);
            case (k)
                K_R:    begin op = OP_RTYPE; while (func == FN_JR || func == FN_SYSCALL) func = 6'($urandom); end
                K_I:    begin op = iops[sel]; exp_alu = ialus[sel]; end
                K_LW:   op = OP_LW;
                K_SW:   op = OP_SW;
                K_BEQ:  op = OP_BEQ;
                K_BNE:  op = OP_BNE;
                K_J:    op = OP_J;
                K_JAL:  op = OP_JAL;
                K_JR:   begin op = OP_RTYPE; func = FN_JR; end
                default: op = OP_COP0;
            endcase
            for (int w = 0; w < fw; w++) begin q.push_back(FETCH); rq.push_back(1'b0); end
            q.push_back(FETCH);  rq.push_back(1'b1);
            q.push_back(DECODE); rq.push_back(1'($urandom));
            case (k)
                K_R: begin q.push_back(EXEC_R); rq.push_back(1'($urandom)); q.push_back(WB_ALU); rq.push_back(1'($urandom)); end
                K_I: begin q.push_back(EXEC_I); rq.push_back(1'($urandom)); q.push_back(WB_ALU); rq.push_back(1'($urandom)); end
                K_LW: begin
                    q.push_back(MEM_ADDR); rq.push_back(1'($urandom));
                    for (int w = 0; w < mw; w++) begin q.push_back(MEM_RD); rq.push_back(1'b0); end
                    q.push_back(MEM_RD); rq.push_back(1'b1);
                    q.push_back(WB_MEM); rq.push_back(1'($urandom));
                end
                K_SW: begin
                    q.push_back(MEM_ADDR); rq.push_back(1'($urandom));
                    for (int w = 0; w < mw; w++) begin q.push_back(MEM_WR); rq.push_back(1'b0); end
                    q.push_back(MEM_WR); rq.push_back(1'b1);
                end
                K_BEQ, K_BNE: begin q.push_back(BRANCH); rq.push_back(1'($urandom)); end
                K_J, K_JAL:   begin q.push_back(JUMP);   rq.push_back(1'($urandom)); end
                K_JR:         begin q.push_back(JR);     rq.push_back(1'($urandom)); end
                default:      begin q.push_back(COP0);   rq.push_back(1'($urandom)); end
            endcase
            for (int c = 0; c < q.size(); c++) begin
                tick(1'b0, rq[c]);
                checks++;
                if (a_state !== q[c]) begin
                    errors++; $display("FAIL rnd_state instr%0d kind=%0d cyc%0d got=%0d exp=%0d", n, k, c, a_state, q[c]);
                end
                if (q[c] == EXEC_I) begin
                    checks++;
                    if (a_aluop !== exp_alu || a_alusrc !== 1'b1) begin
                        errors++; $display("FAIL rnd_ialu instr%0d got=%0d src=%b exp=%0d/1", n, a_aluop, a_alusrc, exp_alu);
                    end
                end
                if (a_regwrite) nrw++;
                if (a_memread)  nmr++;
                if (a_memwrite) nmw++;
            end
            exp_rw = (k == K_R || k == K_I || k == K_LW || k == K_JAL || k == K_COP0) ? 1 : 0;
            exp_mr = fw + 1 + ((k == K_LW) ? mw + 1 : 0);
            exp_mw = (k == K_SW) ? mw + 1 : 0;
            checks++;
            if (nrw != exp_rw || nmr != exp_mr || nmw != exp_mw) begin
                errors++;
                $display("FAIL rnd_strobes instr%0d kind=%0d rw=%0d mr=%0d mw=%0d exp %0d/%0d/%0d",
                         n, k, nrw, nmr, nmw, exp_rw, exp_mr, exp_mw);
            end
        end
        tick(1'b0, 1'b0);
        checks++;
        if (a_state !== FETCH || a_halt !== 1'b0) begin
            errors++; $display("FAIL rnd_end state=%0d halt=%b exp 0/0", a_state, a_halt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_timeout();
        test_halt_ops();
        test_branch_jump();
        test_reset_midwait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctr_unit_mc.md
CTR_UNIT_MC -- requirements
Module: ctr_unit_mc

Interface
REQ-001 MEM_TIMEOUT, default 16, max wait cycles for mem_ready before fault (0 disables timeout).
REQ-002 HAS_COP0, default 1, when 1 op 010000 is legal, when 0 it is illegal.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 op  in  6  instruction opcode from the instruction register.
REQ-006 func  in  6  R-type funct field.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 pcwrite  out  1  PC load strobe.
REQ-009 irwrite  out  1  instruction register load strobe.
REQ-010 iord  out  1  memory address select (0 = PC, 1 = ALU result).
REQ-011 memread / memwrite  out  1 each  memory strobes, held until mem_ready.
REQ-012 regwrite, regdst, memtoreg, alusrc  out  1 each  datapath controls, MIPS meaning.
REQ-013 branch, bneorbeq, jump, isjal, isjr, iscop0  out  1 each  PC-source and special-op flags.
REQ-014 aluop  out  4  ALU operation code from the package.
REQ-015 halt  out  1  sticky stop (syscall, illegal op, timeout).
REQ-016 mem_timeout  out  1  sticky flag set only by a timeout halt.
REQ-017 state  out  4  current FSM state encoding, for debug.

Function
REQ-018 Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JR, COP0, HALT.
REQ-019 FETCH: memread=1, iord=0; when mem_ready=1: irwrite=1, pcwrite=1 (PC+4), aluop=ADD, next DECODE; otherwise stay in FETCH.
REQ-020 DECODE (1 cycle) dispatch:
- R-type: func 001000 -> JR; func 001100 -> HALT; other R-type -> EXEC_R.
- 100011/101011 -> MEM_ADDR.
- 001000/001100/001101/001111 -> EXEC_I.
- 000100/000101 -> BRANCH.
- 000010/000011 -> JUMP.
- 010000 -> COP0 if HAS_COP0=1.
- any other op -> HALT.
REQ-021 EXEC_R: aluop=FUNCT, next WB_ALU with regdst=1. EXEC_I: alusrc=1, aluop per opcode (ADD/AND/OR/LUI), zero-extend for andi/ori, next WB_ALU with regdst=0.
REQ-022 WB_ALU: regwrite=1 for exactly one cycle, next FETCH.
REQ-023 MEM_ADDR: alusrc=1, aluop=ADD, next MEM_RD (lw) or MEM_WR (sw).
REQ-024 MEM_RD: memread=1, iord=1; next WB_MEM on mem_ready. WB_MEM: regwrite=1, memtoreg=1, next FETCH.
REQ-025 MEM_WR: memwrite=1, iord=1; next FETCH on mem_ready.
REQ-026 BRANCH: branch=1, aluop=SUB, bneorbeq=1 for bne; JUMP: jump=1, with isjal=1 and regwrite=1 for jal; JR: isjr=1, pcwrite=1; COP0: iscop0=1, regwrite=1. Each is 1 cycle, next FETCH.
REQ-027 A wait counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0. When count reaches MEM_TIMEOUT (MEM_TIMEOUT not 0): next HALT, mem_timeout=1.
REQ-028 mem_ready=1 in the same cycle the limit is reached: completion wins, no timeout.
REQ-029 HALT: halt=1, all strobes 0, no exit except rst.
REQ-030 Every instruction class costs a fixed cycle count plus memory waits: R/I = 4, lw = 5, sw = 4, branch/jump/jr/cop0 = 3.

Reset
REQ-031 rst=1 at a clock edge forces FETCH, counter=0, halt=0, mem_timeout=0, from any state including mid-wait.
REQ-032 While rst=1, all outputs are driven 0 and state reads FETCH encoding 0000.

Structure
REQ-033 Package ctr_mc_pkg holds the state enum, opcode/funct constants, aluop codes (ADD, SUB, AND, OR, LUI, FUNCT) and the default MEM_TIMEOUT.
REQ-034 Sub-module ctr_decode: combinational op/func -> instruction-class and aluop lookup, used by DECODE.

Verification
REQ-035 add (op 000000, func 100000), mem_ready=1 in FETCH -> states FETCH, DECODE, EXEC_R, WB_ALU; regwrite=1, regdst=1 in cycle 4 only.
REQ-036 lw (100011), mem_ready held 0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with memtoreg=1, regwrite=1; total 8 cycles.
REQ-037 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles; halt=1, mem_timeout=1, sticky; rst clears both.
REQ-038 syscall (func 001100), and op 010000 with HAS_COP0=0 -> HALT with halt=1, mem_timeout=0.
REQ-039 bne (000101) -> BRANCH with branch=1, bneorbeq=1, aluop=SUB; jal (000011) -> isjal=1, jump=1, regwrite=1; both return to FETCH.
REQ-040 rst asserted during MEM_WR wait -> next cycle state=FETCH, memwrite=0, counter=0.
